// File: rtl/color_sensor_qualifier.sv
// Qualifies raw edge/corner colour-sensor codes after a cube move: settle, then
// require a run of identical valid readings, retrying on timeout up to a sticky fault.
module color_sensor_qualifier #(
  parameter int unsigned SETTLE_CYCLES  = 50000,
  parameter int unsigned STABLE_COUNT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       moves_done,
  input  logic       raw_valid,
  input  logic [2:0] raw_edge,
  input  logic [2:0] raw_corner,
  output logic       color_sensor_stable,
  output logic [2:0] edge_color_sensor,
  output logic [2:0] corner_color_sensor,
  output logic       sensor_fault,
  output logic       busy
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MW = $clog2(STABLE_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, FAULT} state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]  cand_e_q, cand_e_d, cand_c_q, cand_c_d;
  logic [2:0]  edge_q, edge_d, corner_q, corner_d;
  logic        stable_q, fault_q, busy_q;

  logic          codes_ok;
  logic          same_pair;
  logic [MW-1:0] match_inc;

  assign codes_ok  = (raw_edge <= 3'd5) && (raw_corner <= 3'd5);
  assign same_pair = (raw_edge == cand_e_q) && (raw_corner == cand_c_q);
  assign match_inc = (match_q >= MW'(STABLE_COUNT)) ? match_q : match_q + MW'(1);

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    cand_e_d = cand_e_q;
    cand_c_d = cand_c_q;
    edge_d   = edge_q;
    corner_d = corner_q;

    unique case (state_q)
      IDLE: begin
        if (moves_done) begin
          state_d  = SETTLE;
          settle_d = '0;
          retry_d  = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d  = SAMPLE;
          settle_d = '0;
          tmo_d    = '0;
          match_d  = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        tmo_d = tmo_q + TW'(1);
        if (raw_valid) begin
          if (!codes_ok) begin
            match_d = '0;
          end else if (match_q == '0 || same_pair) begin
            match_d  = match_inc;
            cand_e_d = raw_edge;
            cand_c_d = raw_corner;
          end else begin
            match_d  = MW'(1);
            cand_e_d = raw_edge;
            cand_c_d = raw_corner;
          end
        end
        // Qualification takes priority over a coincident timeout.
        if (match_d == MW'(STABLE_COUNT)) begin
          state_d  = REPORT;
          edge_d   = cand_e_d;
          corner_d = cand_c_d;
          match_d  = '0;
          tmo_d    = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          retry_d  = retry_q + RW'(1);
          match_d  = '0;
          tmo_d    = '0;
          settle_d = '0;
          state_d  = (retry_d == RW'(MAX_RETRIES)) ? FAULT : SETTLE;
        end
      end
      REPORT:  state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      match_q  <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      cand_e_q <= '0;
      cand_c_q <= '0;
      edge_q   <= '0;
      corner_q <= '0;
      stable_q <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      cand_e_q <= cand_e_d;
      cand_c_q <= cand_c_d;
      edge_q   <= edge_d;
      corner_q <= corner_d;
      stable_q <= (state_d == REPORT);
      fault_q  <= (state_d == FAULT);
      busy_q   <= (state_d == SETTLE) || (state_d == SAMPLE) || (state_d == REPORT);
    end
  end

  assign color_sensor_stable = stable_q;
  assign edge_color_sensor   = edge_q;
  assign corner_color_sensor = corner_q;
  assign sensor_fault        = fault_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_color_sensor_qualifier.sv
// Directed bench for color_sensor_qualifier; expected code pairs are queued at
// stimulus time and checked when the stable pulse appears.
module tb_color_sensor_qualifier;

  localparam int unsigned P_SETTLE  = 4;
  localparam int unsigned P_STABLE  = 3;
  localparam int unsigned P_TIMEOUT = 20;
  localparam int unsigned P_RETRIES = 2;
  localparam int          LATENCY   = 1 + P_SETTLE + P_STABLE;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       moves_done;
  logic       raw_valid;
  logic [2:0] raw_edge;
  logic [2:0] raw_corner;
  logic       color_sensor_stable;
  logic [2:0] edge_color_sensor;
  logic [2:0] corner_color_sensor;
  logic       sensor_fault;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int pulses    = 0;
  logic [5:0] exp_q[$];

  color_sensor_qualifier #(
    .SETTLE_CYCLES (P_SETTLE),
    .STABLE_COUNT  (P_STABLE),
    .TIMEOUT_CYCLES(P_TIMEOUT),
    .MAX_RETRIES   (P_RETRIES)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .moves_done         (moves_done),
    .raw_valid          (raw_valid),
    .raw_edge           (raw_edge),
    .raw_corner         (raw_corner),
    .color_sensor_stable(color_sensor_stable),
    .edge_color_sensor  (edge_color_sensor),
    .corner_color_sensor(corner_color_sensor),
    .sensor_fault       (sensor_fault),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] e, input logic [2:0] c);
    raw_valid  = v;
    raw_edge   = e;
    raw_corner = c;
  endtask

  task automatic wait_stable(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (color_sensor_stable !== 1'b1 && n < maxc);
  endtask

  // Scoreboard: every stable pulse must match the oldest queued pair.
  always @(negedge clock) begin
    logic [5:0] p;
    if (reset_n === 1'b1 && color_sensor_stable === 1'b1) begin
      pulses++;
      chk("stable_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("edge_code", 32'(edge_color_sensor), 32'(p[5:3]));
        chk("corner_code", 32'(corner_color_sensor), 32'(p[2:0]));
      end
    end
  end

  initial begin
    int n;
    logic [2:0] seq_noise [5];
    logic [2:0] seq_inv [6];
    seq_noise = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4};
    seq_inv   = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};

    // Reset held with active request and random raw data
    reset_n    = 1'b0;
    moves_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      step();
      chk("rst_stable", 32'(color_sensor_stable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_edge", 32'(edge_color_sensor), 32'd0);
    chk("rst_corner", 32'(corner_color_sensor), 32'd0);
    chk("rst_fault", 32'(sensor_fault), 32'd0);
    reset_n    = 1'b1;
    moves_done = 1'b0;
    repeat (4) step();
    chk("idle_after_rst", 32'(busy), 32'd0);

    // Clean sample: edge=3 corner=5
    drive(1'b1, 3'd3, 3'd5);
    exp_q.push_back({3'd3, 3'd5});
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    chk("settle_busy", 32'(busy), 32'd1);
    wait_stable(40, n);
    chk("clean_latency", 32'(n + 1), 32'(LATENCY));
    step();
    chk("clean_single_pulse", 32'(color_sensor_stable), 32'd0);
    chk("clean_busy_low", 32'(busy), 32'd0);
    chk("clean_edge_held", 32'(edge_color_sensor), 32'd3);

    // Noise restart: edge 2,2,4,4,4 corner 1
    exp_q.push_back({3'd4, 3'd1});
    drive(1'b0, 3'd0, 3'd0);
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    repeat (P_SETTLE) step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq_noise[i], 3'd1);
      step();
      chk("noise_stable", 32'(color_sensor_stable), (i == 4) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 3'd0, 3'd0);
    step();

    // Invalid code: edge 0,0,7,0,0,0 corner 2
    exp_q.push_back({3'd0, 3'd2});
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    repeat (P_SETTLE) step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq_inv[i], 3'd2);
      step();
      chk("invalid_stable", 32'(color_sensor_stable), (i == 5) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 3'd0, 3'd0);
    step();

    // Request during SAMPLE is ignored
    exp_q.push_back({3'd5, 3'd4});
    drive(1'b1, 3'd5, 3'd4);
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    repeat (5) step();
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    step();
    chk("ignored_first_pulse", 32'(color_sensor_stable), 32'd1);
    repeat (20) step();
    chk("ignored_busy_low", 32'(busy), 32'd0);
    chk("ignored_pulse_count", 32'(pulses), 32'd4);

    // Async reset mid-SETTLE, then restart from IDLE
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    step();
    chk("mid_settle_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_edge", 32'(edge_color_sensor), 32'd0);
    chk("async_corner", 32'(corner_color_sensor), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("restart_idle", 32'(busy), 32'd0);
    exp_q.push_back({3'd2, 3'd0});
    drive(1'b1, 3'd2, 3'd0);
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    wait_stable(40, n);
    chk("restart_latency", 32'(n + 1), 32'(LATENCY));
    step();

    // Timeout twice -> sticky fault
    drive(1'b1, 3'd1, 3'd0);
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 25) chk("retry_resettle_busy", 32'(busy), 32'd1);
      if (k == 48) chk("fault_not_yet", 32'(sensor_fault), 32'd0);
      if (k == 49) begin
        chk("fault_set", 32'(sensor_fault), 32'd1);
        chk("fault_busy", 32'(busy), 32'd0);
      end
      drive(1'b1, (k % 2 == 1) ? 3'd2 : 3'd1, 3'd0);
      step();
    end
    moves_done = 1'b1;
    step();
    moves_done = 1'b0;
    repeat (10) step();
    chk("fault_sticky", 32'(sensor_fault), 32'd1);
    chk("fault_ignores_req", 32'(busy), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("fault_cleared", 32'(sensor_fault), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("total_pulses", 32'(pulses), 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/color_sensor_qualifier.md
Name: color_sensor_qualifier

Overview:
- Sits directly upstream of the cube-state capture FSM. It turns raw, noisy colour-sensor codes into one clean, qualified sample per observation.
- After the motor controller reports a finished move, it waits a mechanical settle time, then requires N consecutive identical valid readings on both sensors.
- It then latches the codes and pulses color_sensor_stable for the capture FSM.
- It retries on timeout and raises a sticky fault when retries are exhausted.

Parameters:
- SETTLE_CYCLES, 50000: cycles waited after moves_done before sampling starts (>=1).
- STABLE_COUNT, 8: consecutive identical valid samples required on both sensors (>=1).
- TIMEOUT_CYCLES, 1000000: maximum cycles in SAMPLE per attempt (> STABLE_COUNT).
- MAX_RETRIES, 3: timed-out attempts allowed before sensor_fault (>=1).

Ports:
- clock  input  1  system clock, all logic on posedge
- reset_n  input  1  asynchronous active-low reset
- moves_done  input  1  one-cycle pulse from spin_all: requested moves have completed
- raw_valid  input  1  raw_edge/raw_corner carry a fresh conversion this cycle
- raw_edge  input  3  edge sensor colour code (W=0, O=1, G=2, Red=3, Blue=4, Y=5; 6 and 7 are invalid)
- raw_corner  input  3  corner sensor colour code, same encoding
- color_sensor_stable  output  1  one-cycle pulse: qualified codes are valid on the outputs
- edge_color_sensor  output  3  latched qualified edge code
- corner_color_sensor  output  3  latched qualified corner code
- sensor_fault  output  1  sticky: retries exhausted
- busy  output  1  high in any state other than IDLE and FAULT

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all counters 0; color_sensor_stable=0; edge_color_sensor=0; corner_color_sensor=0; sensor_fault=0; busy=0.
- States are IDLE, SETTLE, SAMPLE, REPORT, FAULT.
- IDLE: moves_done=1 -> SETTLE; settle counter cleared; retry counter cleared.
- SETTLE:
  - Settle counter increments every cycle.
  - When it reaches SETTLE_CYCLES-1 -> SAMPLE. Total SETTLE dwell is exactly SETTLE_CYCLES cycles.
  - raw_valid is ignored in this state.
- SAMPLE:
  - Timeout counter increments every cycle. Samples count only on cycles with raw_valid=1.
  - On a valid cycle where both codes are <=5:
    - If match count is 0, or both codes equal the held candidate pair, then match count +1 (saturating at STABLE_COUNT) and the candidate pair is updated/held.
    - Otherwise the candidate becomes the new pair and match count = 1.
  - Any code of 6 or 7 on a valid cycle clears match count to 0.
  - When match count reaches STABLE_COUNT -> REPORT, and the candidate pair is loaded into edge_color_sensor/corner_color_sensor the same edge.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without qualifying:
    - Retry counter +1, match count and timeout counter cleared.
    - If retry count (after increment) = MAX_RETRIES -> FAULT; else -> SETTLE (full re-settle).
  - Qualification and timeout on the same cycle: qualification wins.
- REPORT:
  - color_sensor_stable=1 for exactly one cycle; outputs are already valid on that cycle and are held until the next REPORT or reset.
  - Next state IDLE.
- FAULT:
  - sensor_fault=1, sticky. Stays in FAULT until reset_n; color_sensor_stable is never asserted.
- moves_done in any state other than IDLE is ignored; no queuing. The REPORT->IDLE cycle does not accept moves_done.
- Latency: a moves_done pulse on cycle t with clean input from then on (raw_valid=1 every cycle) gives a stable pulse at cycle t+1+SETTLE_CYCLES+STABLE_COUNT.
- All counters are sized $clog2(param+1). No wrap-around is possible, because each counter is cleared on every transition that reuses it.

Test Plan (SETTLE_CYCLES=4, STABLE_COUNT=3, TIMEOUT_CYCLES=20, MAX_RETRIES=2):
- Reset values: hold reset_n=0, drive moves_done=1 and random raw inputs -> all outputs stay 0; state remains IDLE after release until the next moves_done.
- Clean sample: moves_done pulse at cycle 10, raw_valid=1, raw_edge=3, raw_corner=5 constant -> single stable pulse at cycle 18; edge_color_sensor=3, corner_color_sensor=5; busy low afterwards.
- Noise restart: after settle, feed edge codes 2,2,4,4,4 (corner constant 1) -> stable asserted only after the third 4; edge_color_sensor=4, corner_color_sensor=1.
- Invalid code: feed 0,0,7,0,0,0 on edge -> the 7 clears the match count; qualification happens on the third 0 after the 7, never earlier.
- Timeout and fault: alternate edge codes 1/2 every valid cycle -> first timeout re-enters SETTLE; second timeout sets sensor_fault=1 and leaves stable low; a later moves_done has no effect; reset_n clears sensor_fault.
- Ignored request and async reset: pulse moves_done during SAMPLE -> no second report, exactly one stable pulse. Assert reset_n=0 mid-SETTLE -> outputs zero immediately (asynchronously), and the FSM restarts from IDLE.
